// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_PARTIAL = 1'b0;
  localparam logic MODE_FULL    = 1'b1;

endpackage

// File: rtl/mul_digit_2bit.sv
// Combinational partial product: (WIDTH+2)-bit operand times one radix-4 digit.
module mul_digit_2bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH+1:0] x,
  input  logic [1:0]       d,
  output logic [WIDTH+3:0] prod_c
);

  localparam int unsigned OW = WIDTH + 4;

  logic [OW-1:0] xe;

  always_comb begin
    xe = OW'(x);
    unique case (d)
      2'd0:    prod_c = '0;
      2'd1:    prod_c = xe;
      2'd2:    prod_c = xe << 1;
      default: prod_c = (xe << 1) + xe;
    endcase
  end

endmodule

// File: rtl/mul_partial_seq.sv
// Sequential radix-4 unsigned multiplier with partial/full product modes
// and optional early termination once the remaining digits cannot contribute.
module mul_partial_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned CW     = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  localparam logic [PW-1:0] LOW_MASK = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("mul_partial_seq: WIDTH must be even and >= 4");
  end

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [PW-1:0]    a_shift_q;
  logic [WIDTH-1:0] b_shift_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic [PW-1:0]    p_q;

  logic [WIDTH+3:0] pp;
  logic [PW-1:0]    pp_sh;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    a_sh_nxt;
  logic [WIDTH-1:0] b_sh_nxt;
  logic             exit_early;
  logic             finish;

  // Digit product is formed on the latched operand, then aligned by 2*count.
  mul_digit_2bit #(
    .WIDTH (WIDTH)
  ) u_digit (
    .x      ({2'b00, a_q}),
    .d      (b_shift_q[1:0]),
    .prod_c (pp)
  );

  // Next accumulator/shift values; partial mode keeps only the low WIDTH bits.
  always_comb begin
    pp_sh    = PW'(pp) << {cnt_q, 1'b0};
    acc_sum  = acc_q + pp_sh;
    acc_nxt  = (mode_q == MODE_PARTIAL) ? (acc_sum & LOW_MASK) : acc_sum;
    a_sh_nxt = (mode_q == MODE_PARTIAL) ? ((a_shift_q << 2) & LOW_MASK)
                                        : (a_shift_q << 2);
    b_sh_nxt = b_shift_q >> 2;
    exit_early = EARLY_EXIT &&
                 ((b_sh_nxt == '0) || ((mode_q == MODE_PARTIAL) && (a_sh_nxt == '0)));
    finish   = (cnt_q == LAST) || exit_early;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      a_shift_q <= '0;
      b_shift_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_PARTIAL;
      p_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q       <= A;
            a_shift_q <= PW'(A);
            b_shift_q <= B;
            mode_q    <= mode;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          acc_q     <= acc_nxt;
          a_shift_q <= a_sh_nxt;
          b_shift_q <= b_sh_nxt;
          cnt_q     <= cnt_q + CW'(1);
          if (finish) begin
            p_q     <= acc_nxt;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            p_q       <= '0;
            acc_q     <= '0;
            a_shift_q <= '0;
            b_shift_q <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = p_q;

endmodule
